// File: rtl/online_quotient_converter.sv
// On-the-fly conversion of signed-digit quotient digits {-1,0,+1} into a
// two's-complement fraction, keeping Q and QM = Q - ulp so no adder is needed.
module online_quotient_converter #(
  parameter int DIGITS    = 64,
  parameter int CNT_WIDTH = 7
) (
  input  logic              clk,
  input  logic              asyn_reset,
  input  logic              enable_all,
  input  logic              start,
  input  logic              q_valid,
  input  logic [1:0]        q_value,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DIGITS:0]   q_result,
  output logic              digit_error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DIGITS - 1);
  localparam logic [DIGITS:0]      ALL_ONES = '1;

  state_t               state_q, state_d;
  logic [DIGITS:0]      q_q, q_d;
  logic [DIGITS:0]      qm_q, qm_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIGITS:0]      res_q, res_d;
  logic                 err_q, err_d;

  logic                 dig_plus, dig_minus, dig_illegal;
  logic [DIGITS:0]      q_next, qm_next;
  logic                 unused_msb;

  // Shifting left discards the MSB of Q/QM; the sign comes from the digits.
  assign unused_msb = q_q[DIGITS] ^ qm_q[DIGITS];

  assign dig_plus    = (q_value == 2'b10);
  assign dig_minus   = (q_value == 2'b01);
  assign dig_illegal = (q_value == 2'b11);

  // Illegal code 11 falls through to the zero-digit update.
  always_comb begin
    q_next  = {q_q[DIGITS-1:0], 1'b0};
    qm_next = {qm_q[DIGITS-1:0], 1'b1};
    if (dig_plus) begin
      q_next  = {q_q[DIGITS-1:0], 1'b1};
      qm_next = {q_q[DIGITS-1:0], 1'b0};
    end else if (dig_minus) begin
      q_next  = {qm_q[DIGITS-1:0], 1'b1};
      qm_next = {qm_q[DIGITS-1:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONVERT;
          q_d     = '0;
          qm_d    = ALL_ONES;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_CONVERT: begin
        if (q_valid) begin
          q_d   = q_next;
          qm_d  = qm_next;
          cnt_d = cnt_q + 1'b1;
          if (dig_illegal) err_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
            res_d   = q_next;
          end
        end
      end
      S_DONE: begin
        if (result_ready) begin
          if (start) begin
            state_d = S_CONVERT;
            q_d     = '0;
            qm_d    = ALL_ONES;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset wins over enable_all; a low enable_all freezes everything.
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      qm_q    <= ALL_ONES;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else if (enable_all) begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign busy         = (state_q == S_CONVERT);
  assign result_valid = (state_q == S_DONE);
  assign q_result     = res_q;
  assign digit_error  = err_q;

endmodule

// File: tb/tb_online_quotient_converter.sv
// Directed bench for online_quotient_converter with DIGITS=4.
module tb_online_quotient_converter;

  localparam logic [1:0] DP = 2'b10;
  localparam logic [1:0] DM = 2'b01;
  localparam logic [1:0] DZ = 2'b00;
  localparam logic [1:0] DX = 2'b11;

  logic       clk = 1'b0;
  logic       asyn_reset = 1'b1;
  logic       enable_all = 1'b1;
  logic       start = 1'b0;
  logic       q_valid = 1'b0;
  logic [1:0] q_value = 2'b00;
  logic       busy;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic [4:0] q_result;
  logic       digit_error;

  int checks = 0;
  int failures = 0;

  online_quotient_converter #(.DIGITS(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .enable_all(enable_all),
    .start(start), .q_valid(q_valid), .q_value(q_value),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .q_result(q_result), .digit_error(digit_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    asyn_reset = 1'b1;
    step();
    step();
    checks++;
    if ({busy, result_valid, q_result, digit_error} !== 8'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", {busy, result_valid, q_result, digit_error}, 8'b0);
    end
    asyn_reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b rv=%b want 0 0", busy, result_valid);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] vec [4];
    logic [4:0] exp [4];
    vec[0] = {DP, DP, DP, DP}; exp[0] = 5'b01111;
    vec[1] = {DM, DM, DM, DM}; exp[1] = 5'b10001;
    vec[2] = {DP, DM, DZ, DZ}; exp[2] = 5'b00100;
    vec[3] = {DZ, DZ, DZ, DM}; exp[3] = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL pat%0d_busy got=%b want=1", k, busy);
      end
      for (int i = 0; i < 4; i++) begin
        q_valid = 1'b1;
        q_value = vec[k][7-2*i -: 2];
        if (i == 3) begin
          checks++;
          if (result_valid !== 1'b0) begin
            failures++;
            $display("FAIL pat%0d_early_valid got=%b want=0", k, result_valid);
          end
        end
        step();
      end
      q_valid = 1'b0;
      checks++;
      if (result_valid !== 1'b1 || busy !== 1'b0 || q_result !== exp[k]) begin
        failures++;
        $display("FAIL pat%0d_result rv=%b busy=%b q=%b want rv=1 busy=0 q=%b",
                 k, result_valid, busy, q_result, exp[k]);
      end
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL pat%0d_handshake rv=%b busy=%b want 0 0", k, result_valid, busy);
      end
    end
  endtask

  task automatic test_bubbles_enable();
    start = 1'b1; step(); start = 1'b0;
    q_valid = 1'b1; q_value = DP; step();
    q_valid = 1'b0; step();
    q_valid = 1'b1; q_value = DZ; step();
    enable_all = 1'b0; q_valid = 1'b1; q_value = DP; step();
    checks++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL frozen_state busy=%b rv=%b want 1 0", busy, result_valid);
    end
    enable_all = 1'b1; q_valid = 1'b1; q_value = DP; step();
    q_valid = 1'b0; step();
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL bubble_extra_digit rv=%b want=0", result_valid);
    end
    q_valid = 1'b1; q_value = DZ; step();
    q_valid = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || q_result !== 5'b01010) begin
      failures++;
      $display("FAIL bubble_result rv=%b q=%b want rv=1 q=01010", result_valid, q_result);
    end
    enable_all = 1'b0; result_ready = 1'b1; step();
    checks++;
    if (result_valid !== 1'b1) begin
      failures++;
      $display("FAIL frozen_handshake rv=%b want=1", result_valid);
    end
    enable_all = 1'b1; result_ready = 1'b0; q_valid = 1'b1; q_value = DM; step();
    q_valid = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || q_result !== 5'b01010) begin
      failures++;
      $display("FAIL qvalid_in_done rv=%b q=%b want rv=1 q=01010", result_valid, q_result);
    end
    result_ready = 1'b1; step(); result_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q_valid = 1'b1; q_value = DP; step();
    end
    q_valid = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (result_valid !== 1'b1 || busy !== 1'b0 || q_result !== 5'b01111) begin
        failures++;
        $display("FAIL stall%0d rv=%b busy=%b q=%b want rv=1 busy=0 q=01111",
                 c, result_valid, busy, q_result);
      end
    end
    result_ready = 1'b1; step();
    result_ready = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b1 || result_valid !== 1'b0 || q_result !== 5'b01111) begin
      failures++;
      $display("FAIL b2b_restart busy=%b rv=%b q=%b want busy=1 rv=0 q=01111",
               busy, result_valid, q_result);
    end
    for (int i = 0; i < 4; i++) begin
      q_valid = 1'b1; q_value = DM; step();
      if (i < 3) begin
        checks++;
        if (q_result !== 5'b01111) begin
          failures++;
          $display("FAIL b2b_hold%0d q=%b want=01111", i, q_result);
        end
      end
    end
    q_valid = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || q_result !== 5'b10001) begin
      failures++;
      $display("FAIL b2b_result rv=%b q=%b want rv=1 q=10001", result_valid, q_result);
    end
    result_ready = 1'b1; step(); result_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; step(); start = 1'b0;
    q_valid = 1'b1; q_value = DX; step();
    q_value = DP; step();
    q_valid = 1'b0;
    asyn_reset = 1'b1; enable_all = 1'b0; step();
    checks++;
    if ({busy, result_valid, q_result, digit_error} !== 8'b0) begin
      failures++;
      $display("FAIL reset_mid got=%b want=%b", {busy, result_valid, q_result, digit_error}, 8'b0);
    end
    asyn_reset = 1'b0; enable_all = 1'b1; step();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q_valid = 1'b1; q_value = DP; step();
    end
    q_valid = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || q_result !== 5'b01111 || digit_error !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_conv rv=%b q=%b err=%b want rv=1 q=01111 err=0",
               result_valid, q_result, digit_error);
    end
    result_ready = 1'b1; step(); result_ready = 1'b0;
  endtask

  task automatic test_illegal_digit();
    logic [7:0] v;
    v = {DP, DX, DP, DP};
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q_valid = 1'b1; q_value = v[7-2*i -: 2]; step();
    end
    q_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (result_valid !== 1'b1 || q_result !== 5'b01011 || digit_error !== 1'b1) begin
        failures++;
        $display("FAIL illegal%0d rv=%b q=%b err=%b want rv=1 q=01011 err=1",
                 c, result_valid, q_result, digit_error);
      end
      step();
    end
    result_ready = 1'b1; start = 1'b1; step();
    result_ready = 1'b0; start = 1'b0;
    checks++;
    if (digit_error !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL err_cleared err=%b busy=%b want err=0 busy=1", digit_error, busy);
    end
    for (int i = 0; i < 4; i++) begin
      q_valid = 1'b1; q_value = DZ; step();
    end
    q_valid = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || q_result !== 5'b00000 || digit_error !== 1'b0) begin
      failures++;
      $display("FAIL zero_conv rv=%b q=%b err=%b want rv=1 q=00000 err=0",
               result_valid, q_result, digit_error);
    end
    result_ready = 1'b1; step(); result_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_bubbles_enable();
    test_back_to_back();
    test_reset_mid();
    test_illegal_digit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
